// File: rtl/debug_pkg.sv
// Shared definitions for the debug trigger unit and the event dumper that sits behind it.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package debug_pkg;

   // Encoding is shared with the dumper's state constants; keep values stable.
   typedef enum logic [1:0] {
      ST_ARMED = 2'd0,
      ST_POST  = 2'd1,
      ST_DONE  = 2'd2
   } dbg_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debug_sample_filter.sv
// Sample qualifier: passes valid probe samples, optionally only those that differ from the
// last forwarded one (matching samples always pass). Latency: combinational forward, 1-cycle
// history update. Backpressure: none, the dumper accepts every strobe.
// Ports: clk/reset (sync, active-high); enable gates all forwarding; probe_data/probe_valid raw
//        sample; match from the trigger comparator; forward = sample goes to the dumper.
module debug_sample_filter
   import debug_pkg::*;
#(
   parameter int unsigned PROBE_WIDTH       = 32,
   parameter bit          CAPTURE_ON_CHANGE = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [PROBE_WIDTH-1:0] probe_data,
   input  logic                   probe_valid,
   input  logic                   match,
   output logic                   forward
);

   logic [PROBE_WIDTH-1:0] last_q, last_d;
   logic                   have_last_q, have_last_d;

   always_comb begin
      forward     = enable && probe_valid &&
                    (!CAPTURE_ON_CHANGE || !have_last_q || (probe_data != last_q) || match);
      last_d      = last_q;
      have_last_d = have_last_q;
      if (forward) begin
         last_d      = probe_data;
         have_last_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q      <= '0;
         have_last_q <= 1'b0;
      end else begin
         last_q      <= last_d;
         have_last_q <= have_last_d;
      end
   end

endmodule

// File: rtl/debug_trigger_unit.sv
// Trigger qualifier feeding the event dumper: filter, masked match, occurrence count, post window, one trigger pulse.
// Latency: probe -> capture_data/capture_enable/trigger is 1 cycle, all outputs registered.
// Backpressure: none; the dumper takes a sample every cycle capture_enable is high.
// Ports: clk/reset (sync, active-high); probe_data/probe_valid raw probe; force_trigger manual trigger;
//        capture_data/capture_enable to dumper; trigger one-cycle end-of-capture pulse; triggered/done status.
module debug_trigger_unit
   import debug_pkg::*;
#(
   parameter int unsigned            PROBE_WIDTH          = 32,
   parameter logic [PROBE_WIDTH-1:0] TRIGGER_MASK         = {PROBE_WIDTH{1'b1}},
   parameter logic [PROBE_WIDTH-1:0] TRIGGER_VALUE        = '0,
   parameter int unsigned            TRIGGER_OCCURRENCE   = 1,
   parameter int unsigned            POST_TRIGGER_SAMPLES = 16,
   parameter bit                     CAPTURE_ON_CHANGE    = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PROBE_WIDTH-1:0] probe_data,
   input  logic                   probe_valid,
   input  logic                   force_trigger,
   output logic [PROBE_WIDTH-1:0] capture_data,
   output logic                   capture_enable,
   output logic                   trigger,
   output logic                   triggered,
   output logic                   done
);

   localparam int unsigned OCC_W  = clog2_min1(TRIGGER_OCCURRENCE + 1);
   localparam int unsigned POST_W = clog2_min1(POST_TRIGGER_SAMPLES + 1);

   localparam logic [OCC_W-1:0]  OCC_LAST  = OCC_W'(TRIGGER_OCCURRENCE - 1);
   localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
   localparam logic [POST_W-1:0] POST_LOAD = POST_W'(POST_TRIGGER_SAMPLES);
   localparam logic [POST_W-1:0] POST_ONE  = POST_W'(1);

   dbg_state_t             state_q, state_d;
   logic [OCC_W-1:0]       occ_q, occ_d;
   logic [POST_W-1:0]      post_q, post_d;
   logic [PROBE_WIDTH-1:0] cap_data_q, cap_data_d;
   logic                   cap_en_q, cap_en_d;
   logic                   trigger_q, trigger_d;
   logic                   triggered_q, triggered_d;
   logic                   done_q, done_d;

   logic active;
   logic match;
   logic forward;

   // Once DONE the unit is frozen until reset: no forwarding, no matching.
   assign active = (state_q != ST_DONE);
   assign match  = probe_valid && (((probe_data ^ TRIGGER_VALUE) & TRIGGER_MASK) == '0);

   debug_sample_filter #(
      .PROBE_WIDTH       (PROBE_WIDTH),
      .CAPTURE_ON_CHANGE (CAPTURE_ON_CHANGE)
   ) u_filter (
      .clk         (clk),
      .reset       (reset),
      .enable      (active),
      .probe_data  (probe_data),
      .probe_valid (probe_valid),
      .match       (match),
      .forward     (forward)
   );

   always_comb begin
      state_d     = state_q;
      occ_d       = occ_q;
      post_d      = post_q;
      cap_data_d  = cap_data_q;
      cap_en_d    = 1'b0;
      trigger_d   = 1'b0;
      triggered_d = triggered_q;
      done_d      = done_q;

      if (forward) begin
         cap_en_d   = 1'b1;
         cap_data_d = probe_data;
      end

      // Manual trigger wins over any match / post-window bookkeeping this cycle.
      if (active && force_trigger) begin
         trigger_d   = 1'b1;
         triggered_d = 1'b1;
         done_d      = 1'b1;
         state_d     = ST_DONE;
      end else begin
         unique case (state_q)
            ST_ARMED: begin
               if (match) begin
                  if (occ_q == OCC_LAST) begin
                     triggered_d = 1'b1;
                     if (POST_TRIGGER_SAMPLES == 0) begin
                        // Matching sample is the last one: pulse with its own strobe.
                        trigger_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                     end else begin
                        post_d  = POST_LOAD;
                        state_d = ST_POST;
                     end
                  end else if (occ_q != '1) begin
                     occ_d = occ_q + OCC_ONE;
                  end
               end
            end
            ST_POST: begin
               if (forward) begin
                  post_d = post_q - POST_ONE;
                  // Pulse lands on the same cycle as the final post sample's strobe.
                  if (post_q == POST_ONE) begin
                     trigger_d = 1'b1;
                     done_d    = 1'b1;
                     state_d   = ST_DONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ARMED;
         occ_q       <= '0;
         post_q      <= '0;
         cap_data_q  <= '0;
         cap_en_q    <= 1'b0;
         trigger_q   <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         occ_q       <= occ_d;
         post_q      <= post_d;
         cap_data_q  <= cap_data_d;
         cap_en_q    <= cap_en_d;
         trigger_q   <= trigger_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
      end
   end

   assign capture_data   = cap_data_q;
   assign capture_enable = cap_en_q;
   assign trigger        = trigger_q;
   assign triggered      = triggered_q;
   assign done           = done_q;

endmodule

// File: tb/tb_debug_trigger_unit.sv
// Bench for debug_trigger_unit: four instances with different build parameters share one clock and reset.
// Expected outputs are pushed to a scoreboard queue as each cycle's stimulus is driven and popped after the edge.
// Instance 0: defaults. 1: occurrence 3, no post window, value 0x55. 2: change-only. 3: mask 0xF0 value 0x30, no post window.
module tb_debug_trigger_unit;

   typedef struct packed {
      logic        en;
      logic [31:0] dat;
      logic        trig;
      logic        trgd;
      logic        done;
      logic        dat_chk;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] p_dat [4];
   logic        p_vld [4];
   logic        p_frc [4];
   logic [31:0] c_dat [4];
   logic        c_en  [4];
   logic        c_trg [4];
   logic        c_tgd [4];
   logic        c_dn  [4];

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   debug_trigger_unit u0 (
      .clk(clk), .reset(rst), .probe_data(p_dat[0]), .probe_valid(p_vld[0]), .force_trigger(p_frc[0]),
      .capture_data(c_dat[0]), .capture_enable(c_en[0]), .trigger(c_trg[0]), .triggered(c_tgd[0]), .done(c_dn[0]));

   debug_trigger_unit #(.TRIGGER_VALUE(32'h55), .TRIGGER_OCCURRENCE(3), .POST_TRIGGER_SAMPLES(0)) u1 (
      .clk(clk), .reset(rst), .probe_data(p_dat[1]), .probe_valid(p_vld[1]), .force_trigger(p_frc[1]),
      .capture_data(c_dat[1]), .capture_enable(c_en[1]), .trigger(c_trg[1]), .triggered(c_tgd[1]), .done(c_dn[1]));

   debug_trigger_unit #(.CAPTURE_ON_CHANGE(1'b1)) u2 (
      .clk(clk), .reset(rst), .probe_data(p_dat[2]), .probe_valid(p_vld[2]), .force_trigger(p_frc[2]),
      .capture_data(c_dat[2]), .capture_enable(c_en[2]), .trigger(c_trg[2]), .triggered(c_tgd[2]), .done(c_dn[2]));

   debug_trigger_unit #(.TRIGGER_MASK(32'h0000_00F0), .TRIGGER_VALUE(32'h30), .POST_TRIGGER_SAMPLES(0)) u3 (
      .clk(clk), .reset(rst), .probe_data(p_dat[3]), .probe_valid(p_vld[3]), .force_trigger(p_frc[3]),
      .capture_data(c_dat[3]), .capture_enable(c_en[3]), .trigger(c_trg[3]), .triggered(c_tgd[3]), .done(c_dn[3]));

   function automatic exp_t mk(input logic en, input logic [31:0] dat, input logic trig,
                               input logic trgd, input logic done);
      exp_t e;
      e.en = en; e.dat = dat; e.trig = trig; e.trgd = trgd; e.done = done;
      e.dat_chk = en;
      return e;
   endfunction

   function automatic exp_t get_obs(input int k);
      exp_t o;
      o.en = c_en[k]; o.dat = c_dat[k]; o.trig = c_trg[k]; o.trgd = c_tgd[k]; o.done = c_dn[k];
      o.dat_chk = 1'b0;
      return o;
   endfunction

   task automatic drive(input int k, input logic v, input logic [31:0] d, input logic f);
      p_vld[k] = v;
      p_dat[k] = d;
      p_frc[k] = f;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) drive(k, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Reset with busy inputs (including force) must clear everything, and stay clear when idle.
   task automatic test_reset();
      exp_t e, o;
      for (int r = 0; r < 2; r++) begin
         rst = (r == 0);
         for (int k = 0; k < 4; k++) begin
            if (r == 0) drive(k, 1'b1, 32'h0, 1'b1);
            else        drive(k, 1'b0, 32'h0, 1'b0);
            e = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            e.dat_chk = 1'b1;
            sb.push_back(e);
         end
         @(posedge clk); #1;
         for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            o = get_obs(k);
            o.dat_chk = e.dat_chk;
            n_cmp++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL reset u%0d round %0d: got en=%b dat=%h trig=%b trgd=%b done=%b, want all zero",
                        k, r, o.en, o.dat, o.trig, o.trgd, o.done);
            end
         end
      end
   endtask

   // Defaults: 1,2,3 then match 0, then 16 post samples with one invalid cycle in between.
   task automatic test_default();
      exp_t e, o;
      logic [31:0] d;
      logic v;
      pulse_reset();
      for (int i = 0; i < 24; i++) begin
         v = (i != 10);
         d = (i == 3) ? 32'h0 : 32'(i + 1);
         drive(0, v, d, 1'b0);
         if (i < 3)        e = mk(1'b1, d, 1'b0, 1'b0, 1'b0);
         else if (i == 3)  e = mk(1'b1, d, 1'b0, 1'b1, 1'b0);
         else if (i == 10) e = mk(1'b0, d, 1'b0, 1'b1, 1'b0);
         else if (i < 20)  e = mk(1'b1, d, 1'b0, 1'b1, 1'b0);
         else if (i == 20) e = mk(1'b1, d, 1'b1, 1'b1, 1'b1);
         else              e = mk(1'b0, d, 1'b0, 1'b1, 1'b1);
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         o = get_obs(0);
         o.dat_chk = e.dat_chk;
         if (!e.dat_chk) o.dat = e.dat;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL default[%0d]: got en=%b dat=%h trig=%b trgd=%b done=%b, want en=%b dat=%h trig=%b trgd=%b done=%b",
                     i, o.en, o.dat, o.trig, o.trgd, o.done, e.en, e.dat, e.trig, e.trgd, e.done);
         end
      end
   endtask

   // Third match (cycle 9) completes the sequence; no post window so trigger rides its strobe.
   task automatic test_occurrence();
      exp_t e, o;
      logic [31:0] d;
      pulse_reset();
      for (int i = 0; i < 12; i++) begin
         d = (i == 2 || i == 5 || i == 9) ? 32'h55 : 32'(i);
         drive(1, 1'b1, d, 1'b0);
         if (i < 9)       e = mk(1'b1, d, 1'b0, 1'b0, 1'b0);
         else if (i == 9) e = mk(1'b1, d, 1'b1, 1'b1, 1'b1);
         else             e = mk(1'b0, d, 1'b0, 1'b1, 1'b1);
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         o = get_obs(1);
         o.dat_chk = e.dat_chk;
         if (!e.dat_chk) o.dat = e.dat;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL occurrence[%0d]: got en=%b dat=%h trig=%b trgd=%b done=%b, want en=%b dat=%h trig=%b trgd=%b done=%b",
                     i, o.en, o.dat, o.trig, o.trgd, o.done, e.en, e.dat, e.trig, e.trgd, e.done);
         end
      end
   endtask

   // Change-only: repeats dropped, repeated matching value 0 still forwarded.
   task automatic test_change();
      exp_t e, o;
      logic [31:0] cd [10] = '{32'd7, 32'd7, 32'd7, 32'd8, 32'd8, 32'd7, 32'd0, 32'd0, 32'd7, 32'd7};
      logic        ce [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      pulse_reset();
      for (int i = 0; i < 10; i++) begin
         drive(2, 1'b1, cd[i], 1'b0);
         e = mk(ce[i], cd[i], 1'b0, (i >= 6), 1'b0);
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         o = get_obs(2);
         o.dat_chk = e.dat_chk;
         if (!e.dat_chk) o.dat = e.dat;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL change[%0d]: got en=%b dat=%h trig=%b trgd=%b done=%b, want en=%b dat=%h trig=%b trgd=%b done=%b",
                     i, o.en, o.dat, o.trig, o.trgd, o.done, e.en, e.dat, e.trig, e.trgd, e.done);
         end
      end
   endtask

   // Masked compare: 0x3 misses, invalid 0x30 ignored, 0x1234_5637 hits.
   task automatic test_mask();
      exp_t e, o;
      logic [31:0] md [4] = '{32'h3, 32'h30, 32'h1234_5637, 32'h1234_5637};
      logic        mv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         drive(3, mv[i], md[i], 1'b0);
         if (i == 0)      e = mk(1'b1, md[i], 1'b0, 1'b0, 1'b0);
         else if (i == 1) e = mk(1'b0, md[i], 1'b0, 1'b0, 1'b0);
         else if (i == 2) e = mk(1'b1, md[i], 1'b1, 1'b1, 1'b1);
         else             e = mk(1'b0, md[i], 1'b0, 1'b1, 1'b1);
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         o = get_obs(3);
         o.dat_chk = e.dat_chk;
         if (!e.dat_chk) o.dat = e.dat;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mask[%0d]: got en=%b dat=%h trig=%b trgd=%b done=%b, want en=%b dat=%h trig=%b trgd=%b done=%b",
                     i, o.en, o.dat, o.trig, o.trgd, o.done, e.en, e.dat, e.trig, e.trgd, e.done);
         end
      end
   endtask

   // Force in ARMED: trigger next cycle with that cycle's strobe, then frozen (later match/force ignored).
   task automatic test_force();
      exp_t e, o;
      logic [31:0] fd [5] = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd5};
      logic        ff [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'b1, fd[i], ff[i]);
         if (i < 2)       e = mk(1'b1, fd[i], 1'b0, 1'b0, 1'b0);
         else if (i == 2) e = mk(1'b1, fd[i], 1'b1, 1'b1, 1'b1);
         else             e = mk(1'b0, fd[i], 1'b0, 1'b1, 1'b1);
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         o = get_obs(0);
         o.dat_chk = e.dat_chk;
         if (!e.dat_chk) o.dat = e.dat;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL force[%0d]: got en=%b dat=%h trig=%b trgd=%b done=%b, want en=%b dat=%h trig=%b trgd=%b done=%b",
                     i, o.en, o.dat, o.trig, o.trgd, o.done, e.en, e.dat, e.trig, e.trgd, e.done);
         end
      end
   endtask

   // Reset with 8 post samples left, then a fresh match must run the full 16-sample window.
   task automatic test_reset_mid_post();
      exp_t e, o;
      logic [31:0] d;
      pulse_reset();
      for (int i = 0; i < 28; i++) begin
         rst = (i == 9);
         d = (i == 0 || i == 9 || i == 10) ? 32'h0 : 32'(100 + i);
         drive(0, 1'b1, d, 1'b0);
         if (i == 9) begin
            e = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            e.dat_chk = 1'b1;
         end else if (i < 26) e = mk(1'b1, d, 1'b0, 1'b1, 1'b0);
         else if (i == 26)    e = mk(1'b1, d, 1'b1, 1'b1, 1'b1);
         else                 e = mk(1'b0, d, 1'b0, 1'b1, 1'b1);
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         o = get_obs(0);
         o.dat_chk = e.dat_chk;
         if (!e.dat_chk) o.dat = e.dat;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_post[%0d]: got en=%b dat=%h trig=%b trgd=%b done=%b, want en=%b dat=%h trig=%b trgd=%b done=%b",
                     i, o.en, o.dat, o.trig, o.trgd, o.done, e.en, e.dat, e.trig, e.trgd, e.done);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 4; k++) drive(k, 1'b0, 32'h0, 1'b0);
      #1;
      test_reset();
      test_default();
      test_occurrence();
      test_change();
      test_mask();
      test_force();
      test_reset_mid_post();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_trigger_unit.md
Name: debug_trigger_unit

Overview:
- Qualifier stage directly upstream of the on-chip event dumper: turns a raw probe bus into its capture_data / capture_enable / trigger inputs.
- Filters samples (valid, optional change-only), detects a masked match, counts occurrences, runs a post-trigger sample window, then issues a single trigger pulse so the dumper's ring holds pre- and post-event history.
- Configuration is fixed by parameters at FPGA build time.

Parameters:
PROBE_WIDTH, 32, width of probe bus and capture_data
TRIGGER_MASK, {PROBE_WIDTH{1'b1}}, bits compared for a match
TRIGGER_VALUE, 0, value compared under mask
TRIGGER_OCCURRENCE, 1, Nth match arms the post window (must be >= 1)
POST_TRIGGER_SAMPLES, 16, captured samples after the matching sample (0 allowed)
CAPTURE_ON_CHANGE, 0, 1 = forward only samples differing from last forwarded one

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
probe_data  in  PROBE_WIDTH  raw observed value
probe_valid  in  1  probe_data meaningful this cycle
force_trigger  in  1  manual trigger (e.g. pushbutton, already synchronised)
capture_data  out  PROBE_WIDTH  registered sample to dumper
capture_enable  out  1  registered write strobe to dumper
trigger  out  1  one-cycle pulse ending capture
triggered  out  1  status: match sequence complete (post window running or done)
done  out  1  status: trigger has been issued

Behaviour:
- One clock, clk; reset synchronous active-high. On reset: capture_data=0, capture_enable=0, trigger=0, triggered=0, done=0, occurrence count=0, post count=0, have_last=0, state=ARMED.
- All outputs registered; latency probe -> capture_data/capture_enable = 1 cycle.
- match = probe_valid && (((probe_data ^ TRIGGER_VALUE) & TRIGGER_MASK) == 0).
- forward = probe_valid && (CAPTURE_ON_CHANGE==0 || !have_last || probe_data != last || match). Matching samples are always forwarded. On forward: last <= probe_data, have_last <= 1.
- States:
  - ARMED: forward -> capture_enable=1 next cycle. On match: if occ_count == TRIGGER_OCCURRENCE-1, the sequence completes; else occ_count++ (saturating, width $clog2(TRIGGER_OCCURRENCE+1)). On completion: triggered<=1; if POST_TRIGGER_SAMPLES==0, trigger<=1 in the same cycle the matching sample's capture_enable rises, then DONE; else post_count<=POST_TRIGGER_SAMPLES, go POST.
  - POST: forward as in ARMED; further matches are ignored. Each forwarded sample decrements post_count. The forward that moves post_count 1->0 also sets trigger<=1, so trigger coincides with the last post sample's capture_enable; go DONE.
  - DONE: capture_enable=0, trigger=0, done=1, triggered=1; probe and force_trigger are ignored until reset.
- force_trigger high in ARMED or POST: next cycle trigger=1 (together with capture_enable if that cycle's sample forwarded), triggered=1, done=1, state DONE. This overrides an in-progress match/post count in the same cycle.
- trigger is high for exactly one cycle per reset. Never asserted without the dumper having seen its final sample's strobe in the same cycle.
- probe_valid=0: no forward, no match, counts hold.
- Reset mid-POST or mid-occurrence count discards all progress; next cycle ARMED with counts 0.
- Widths: post_count $clog2(POST_TRIGGER_SAMPLES+1) (minimum 1); no wrap possible by construction.

Decomposition:
- Package debug_pkg: state enum (ARMED, POST, DONE) as a 2-bit typedef; this state encoding is shared with the dumper's state constants.
- One natural sub-module: debug_sample_filter (valid/change-only filter holding last/have_last, outputs forward). The match comparator and FSM stay in the top level.

Test Plan:
- Defaults, probe 1,2,3,0,5 valid every cycle -> capture_enable each cycle 1 cycle late; POST entered on 0; trigger on 16th forwarded sample after 0; done=1 thereafter; no further strobes.
- TRIGGER_OCCURRENCE=3, POST=0, value 0x55 on cycles 2,5,9 -> triggered and trigger rise with the capture_enable of the cycle-9 sample, not earlier.
- CAPTURE_ON_CHANGE=1, probe 7,7,7,8,8,7 -> strobes only for samples 1,4,6 (7,8,7); repeated matching value 0 is still forwarded.
- TRIGGER_MASK=0x0000_00F0, TRIGGER_VALUE=0x30: probe 0x1234_5637 matches, 0x3 does not; probe_valid=0 with matching data -> no match.
- force_trigger pulse in ARMED, POST=16 -> trigger exactly next cycle, done=1, no post samples.
- Reset asserted mid-POST (8 samples left) -> next cycle all outputs 0, ARMED; a new match restarts the full 16-sample window.
